// File: rtl/lcu_adder_pipe.sv
// lcu_adder_pipe
//   Pipelined WIDTH-bit add/subtract. The word is cut into WIDTH/BLOCK
//   segments. Each pipeline stage resolves one segment with 4-bit lookahead
//   groups, and the segment carry is registered into the next stage. Operand
//   bits above the resolved segment ride forward in the same word register
//   that collects the finished sum bits below it. Latency is STAGES cycles.
//   A single global advance enable stalls every stage together.
//   WIDTH must be a multiple of BLOCK, and BLOCK a multiple of 4.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   operand beat handshake (in_ready = advance)
//   a, b, cin, sub      operands; sub=1 computes a + ~b + 1 and ignores cin
//   out_valid/out_ready result beat handshake
//   sum, cout, ovf      result, carry out of the MSB, signed overflow
//   zero                sum == 0
//   pg, gg              whole-word group propagate / generate (cin-independent)
module lcu_adder_pipe #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             pg,
  output logic             gg
);

  localparam int STAGES = WIDTH / BLOCK;
  localparam int NGRP   = BLOCK / 4;

  typedef struct packed {
    logic [BLOCK-1:0] s;      // segment sum
    logic             co;     // carry out of the segment
    logic             c_top;  // carry into the top bit of the segment
    logic             pg;     // segment group propagate
    logic             gg;     // segment group generate (carry-in = 0)
  } seg_res_t;

  // One segment: 4-bit group PG/GG, a lookahead unit over the group carries,
  // then lookahead bit carries inside each group from its group carry-in.
  function automatic seg_res_t seg_add(input logic [BLOCK-1:0] x,
                                       input logic [BLOCK-1:0] y,
                                       input logic             ci);
    seg_res_t        r;
    logic [BLOCK-1:0] p, g, c;
    logic [NGRP:0]    gc;
    logic [NGRP-1:0]  grp_p, grp_g;
    logic [3:0]       p4, g4;
    logic             cg, acc;
    p     = x ^ y;
    g     = x & y;
    grp_p = '0;
    grp_g = '0;
    c     = '0;
    for (int j = 0; j < NGRP; j++) begin
      p4       = p[4*j +: 4];
      g4       = g[4*j +: 4];
      grp_p[j] = &p4;
      grp_g[j] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) |
                 (p4[3] & p4[2] & p4[1] & g4[0]);
    end
    gc[0] = ci;
    for (int j = 0; j < NGRP; j++) begin
      gc[j+1] = grp_g[j] | (grp_p[j] & gc[j]);
    end
    for (int j = 0; j < NGRP; j++) begin
      p4         = p[4*j +: 4];
      g4         = g[4*j +: 4];
      cg         = gc[j];
      c[4*j]     = cg;
      c[4*j + 1] = g4[0] | (p4[0] & cg);
      c[4*j + 2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cg);
      c[4*j + 3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) |
                   (p4[2] & p4[1] & p4[0] & cg);
    end
    acc = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      acc = grp_g[j] | (grp_p[j] & acc);
    end
    r.s     = p ^ c;
    r.co    = gc[NGRP];
    r.c_top = c[BLOCK-1];
    r.pg    = &grp_p;
    r.gg    = acc;
    return r;
  endfunction

  // Per-stage state. word holds finished sum bits below the stage's segment
  // and still-unprocessed bits of a above it; bx holds b' (already inverted
  // for subtract), so the mode never needs to travel separately.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [STAGES-1:0] pg_q, pg_d;
  logic [STAGES-1:0] gg_q, gg_d;
  logic [WIDTH-1:0]  word_q [STAGES];
  logic [WIDTH-1:0]  word_d [STAGES];
  logic [WIDTH-1:0]  bx_q   [STAGES];
  logic [WIDTH-1:0]  bx_d   [STAGES];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              advance;

  assign advance  = !vld_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  always_comb begin
    logic [WIDTH-1:0] x_w, y_w;
    logic             ci, pgi, ggi, vi;
    seg_res_t         r;
    vld_d  = '0;
    cy_d   = '0;
    pg_d   = '0;
    gg_d   = '0;
    ovf_d  = 1'b0;
    zero_d = 1'b0;
    r      = '0;
    // stage 0 inputs come straight from the ports
    x_w = a;
    y_w = sub ? ~b : b;
    ci  = sub | cin;
    pgi = 1'b1;
    ggi = 1'b0;
    vi  = in_valid;
    for (int k = 0; k < STAGES; k++) begin
      r                           = seg_add(x_w[k*BLOCK +: BLOCK], y_w[k*BLOCK +: BLOCK], ci);
      word_d[k]                   = x_w;
      word_d[k][k*BLOCK +: BLOCK] = r.s;
      bx_d[k]                     = y_w;
      cy_d[k]                     = r.co;
      pg_d[k]                     = pgi & r.pg;
      gg_d[k]                     = r.gg | (r.pg & ggi);
      vld_d[k]                    = vi;
      if (k == STAGES - 1) begin
        // last stage: flags need the full word, ready now
        ovf_d  = r.c_top ^ r.co;
        zero_d = (word_d[k] == '0);
      end else begin
        // stage k+1 boundary: next stage reads this stage's registers
        x_w = word_q[k];
        y_w = bx_q[k];
        ci  = cy_q[k];
        pgi = pg_q[k];
        ggi = gg_q[k];
        vi  = vld_q[k];
      end
    end
  end

  // Output stage registers are cleared on reset; inner data registers only
  // matter when their valid bit is set, so reset leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q             <= '0;
      cy_q              <= '0;
      pg_q              <= '0;
      gg_q              <= '0;
      word_q[STAGES-1]  <= '0;
      ovf_q             <= 1'b0;
      zero_q            <= 1'b0;
    end else if (advance) begin
      vld_q  <= vld_d;
      cy_q   <= cy_d;
      pg_q   <= pg_d;
      gg_q   <= gg_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int k = 0; k < STAGES; k++) begin
        word_q[k] <= word_d[k];
        bx_q[k]   <= bx_d[k];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = word_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];
  assign pg        = pg_q[STAGES-1];
  assign gg        = gg_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_lcu_adder_pipe.sv
// Testbench for lcu_adder_pipe (WIDTH=64, BLOCK=16, latency 4).
// Stimulus pushes expected results into a queue on acceptance; an output
// monitor pops and compares whenever a result beat is transferred.
module tb_lcu_adder_pipe;

  localparam int W = 64;
  localparam int LAT = 4;

  typedef logic [W+4:0] vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout, ovf, zero, pg, gg;

  lcu_adder_pipe #(.WIDTH(64), .BLOCK(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .pg(pg), .gg(gg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout, ovf, zero, pg, gg;
    int           cyc;
    int           stl;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  bit   rnd_done = 0;

  task automatic chk(input string name, input vec_t act, input vec_t req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: plain wide arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c_in, input logic s);
    exp_t         e;
    logic [W-1:0] yp;
    logic         c0;
    logic [W:0]   full, nocarry;
    logic [W+1:0] wide;
    yp      = s ? ~y : y;
    c0      = s ? 1'b1 : c_in;
    full    = {1'b0, x} + {1'b0, yp} + {{W{1'b0}}, c0};
    nocarry = {1'b0, x} + {1'b0, yp};
    wide    = {{2{x[W-1]}}, x} + {{2{yp[W-1]}}, yp} + {{(W+1){1'b0}}, c0};
    e.sum   = full[W-1:0];
    e.cout  = full[W];
    e.ovf   = (wide != {{2{full[W-1]}}, full[W-1:0]});
    e.zero  = (full[W-1:0] == '0);
    e.pg    = &(x ^ yp);
    e.gg    = nocarry[W];
    e.cyc   = 0;
    e.stl   = 0;
    return e;
  endfunction

  function automatic vec_t exp_vec(input exp_t e);
    return {e.sum, e.cout, e.ovf, e.zero, e.pg, e.gg};
  endfunction

  // Input side: record every accepted beat (transfer happens at next posedge).
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_t e;
      e     = model(a, b, cin, sub);
      e.cyc = cyc;
      e.stl = stall_cnt;
      exp_q.push_back(e);
    end
  end

  // Output monitor.
  logic hold_prev = 1'b0;
  vec_t held_vec;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev)
        chk("held_output_stable", {sum, cout, ovf, zero, pg, gg}, held_vec);
      if (out_valid && out_ready) begin
        chk("result_expected", vec_t'(exp_q.size() > 0), vec_t'(1));
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("result", {sum, cout, ovf, zero, pg, gg}, exp_vec(mon_e));
          chk("latency", vec_t'(cyc - mon_e.cyc), vec_t'(LAT + stall_cnt - mon_e.stl));
        end
      end
      hold_prev <= out_valid && !out_ready;
      held_vec  <= {sum, cout, ovf, zero, pg, gg};
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic cc, input logic ss);
    bit took;
    took     = 0;
    a        = aa;
    b        = bb;
    cin      = cc;
    sub      = ss;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !took; t++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accepted", vec_t'(took), vec_t'(1));
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick();
    chk("drained", vec_t'(exp_q.size()), vec_t'(0));
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(7))
      0: return '1;
      1: return '0;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hv [16];
    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_outputs", {sum, cout, ovf, zero, pg, gg}, vec_t'(0));
    chk("reset_out_valid", vec_t'(out_valid), vec_t'(0));
    @(negedge clk);
    chk("reset_in_ready", vec_t'(in_ready), vec_t'(1));
    tick();

    // Directed cases, back-to-back
    send('0, '1, 1'b0, 1'b0);
    send('1, '1, 1'b0, 1'b0);
    send(64'd1, '1, 1'b0, 1'b0);
    send('1, '0, 1'b1, 1'b0);
    send(64'd5, 64'd7, 1'b0, 1'b1);
    send(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
    drain();

    // Backpressure: hold out_ready low for 3 cycles once a result shows up
    fork
      begin
        for (int i = 0; i < 6; i++) send(rand_op(), rand_op(), 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      begin
        bit seen;
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk);
          seen = out_valid;
        end
        chk("bp_out_valid_seen", vec_t'(seen), vec_t'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", vec_t'(in_ready), vec_t'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-flight discards everything in the pipe
    send(rand_op(), rand_op(), 1'b0, 1'b0);
    send(rand_op(), rand_op(), 1'b1, 1'b0);
    send(rand_op(), rand_op(), 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      chk("no_output_after_reset", vec_t'(out_valid), vec_t'(0));
    end
    tick();
    send(64'h1111_1111_1111_1111, 64'hEEEE_EEEE_EEEE_EEEE, 1'b0, 1'b0);
    drain();

    // Bubbles with sub toggling per beat: out_valid is in_valid delayed 4
    for (int i = 0; i < 16; i++) begin
      in_valid = (i < 12) && (i % 2 == 0);
      sub      = 1'((i / 2) % 2);
      cin      = 1'($urandom_range(1));
      a        = rand_op();
      b        = rand_op();
      @(negedge clk);
      hv[i] = in_valid && in_ready;
      chk("bubble_pattern", vec_t'(out_valid), vec_t'((i >= LAT) ? hv[i-LAT] : 1'b0));
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Random traffic with random backpressure
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          if ($urandom_range(3) == 0) repeat ($urandom_range(2, 1)) tick();
          send(rand_op(), rand_op(), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lcu_adder_pipe.md
Name: lcu_adder_pipe

Overview:
- Parametrised, pipelined successor to the 64-bit combinational lookahead-carry-unit adder.
- WIDTH-bit add/subtract split into WIDTH/BLOCK segments; each pipeline stage resolves one segment with 4-bit lookahead groups and registers the inter-segment carry.
- Valid/ready handshake with global stall; feeds the ALU result bus and flag logic.

Parameters:
- WIDTH, 64, operand and result width; must be a multiple of BLOCK.
- BLOCK, 16, bits resolved per stage; must be a multiple of 4.
- STAGES = WIDTH/BLOCK (derived, not overridable); this is the latency in cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b (a+~b+1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1; for sub, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR cout.
- zero  output  1  sum == 0.
- pg  output  1  whole-word group propagate: AND over all bits of (a XOR b').
- gg  output  1  whole-word group generate: carry out with carry-in forced to 0.
- Note: b' = sub ? ~b : b.

Behaviour:
- Reset (synchronous, active-high): clears every stage valid bit and all output registers. out_valid=0; sum, cout, ovf, zero, pg, gg = 0. in_ready=1 in the cycle after reset deasserts.
- A reset asserted mid-operation discards all in-flight beats. No result for those beats ever appears.
- advance = !out_valid || out_ready. in_ready = advance; it is combinational from out_ready.
- A beat is accepted when in_valid && in_ready.
- When advance=0, every stage register, including the output registers, holds. sum and flags stay stable while out_valid=1 && out_ready=0.
- Stage k (0..STAGES-1) computes segment bits [k*BLOCK +: BLOCK]:
  - per-bit p = a^b', g = a&b'.
  - 4-bit groups produce PG/GG; an in-stage LCU derives the group carries.
  - The registered segment carry-out feeds stage k+1.
  - Stage 0 carry-in = sub ? 1 : cin.
- Operands are skewed: upper segments ride delay registers until their stage. Lower sum segments ride delay registers until the output.
- The full-width result and flags present together at out_valid, exactly STAGES cycles after acceptance when there is no stall.
- Each stall cycle adds exactly one cycle of latency to every in-flight beat.
- Throughput: one beat per cycle while out_ready=1. Bubbles (in_valid=0) propagate as valid=0 and never produce out_valid.
- Beats emerge strictly in acceptance order. None are dropped or duplicated.
- pg and gg are accumulated per stage (gg_k = GG_seg | PG_seg & gg_{k-1}, starting from 0) and registered alongside the data. They are independent of cin.
- The sub operation and cin are captured at acceptance and travel with the beat. Mode changes between consecutive beats are legal.
- Simultaneous accept and emit in one cycle is legal when out_ready=1.
- Full pipeline with out_ready=0: in_ready=0. Any beat offered with in_valid=1 is not accepted and must be held by the source.

Test Plan (WIDTH=64, BLOCK=16, latency 4):
- Cases 1–3, back-to-back, cin=0, sub=0, out_ready=1:
  - a=0, b=FFFF_FFFF_FFFF_FFFF -> sum=FFFF_FFFF_FFFF_FFFF, cout=0, pg=1, gg=0.
  - a=b=FFFF_FFFF_FFFF_FFFF -> sum=FFFF_FFFF_FFFF_FFFE, cout=1, gg=1.
  - a=1, b=FFFF_FFFF_FFFF_FFFF -> sum=0, cout=1, zero=1.
  - Results appear on cycles 4, 5 and 6 after the first accept.
- Carry ripple across all segments: a=FFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, zero=1, pg=1, gg=0.
- Subtract:
  - sub=1, a=5, b=7 -> sum=FFFF_FFFF_FFFF_FFFE, cout=0.
  - sub=1, a=8000_0000_0000_0000, b=1 -> sum=7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Backpressure: stream 6 beats; hold out_ready=0 for 3 cycles once out_valid=1.
  - in_ready drops once the pipeline fills.
  - The held output is stable.
  - All 6 results arrive in order; none are lost.
- Reset mid-flight: accept 3 beats, then assert reset for 1 cycle -> out_valid stays 0 for 4 cycles with no stray results. A new beat a=1111_1111_1111_1111, b=EEEE_EEEE_EEEE_EEEE yields sum=FFFF_FFFF_FFFF_FFFF with latency 4.
- Bubbles plus mode interleave: alternate in_valid 1/0 with sub toggling per beat -> out_valid pattern matches the input pattern delayed by 4 cycles, with per-beat results correct.
